// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states, op encoding.
package muldiv_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  // MFHI/MTHI/MFLO/MTLO share 0100xx, MULT/MULTU/DIV/DIVU share 0110xx.
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

  function automatic logic is_arith(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration on {acc, q}: shift-add for multiply, restoring subtract for divide.
module muldiv_iter_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc_next,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_add      = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
    w_shl      = {i_acc, i_q[WIDTH-1]};
    w_diff     = w_shl - {1'b0, i_b};
    o_acc_next = w_add[WIDTH:1];
    o_q_next   = {w_add[0], i_q[WIDTH-1:1]};
    if (i_op == OP_DIV) begin
      // Borrow out of the (WIDTH+1)-bit subtract means the partial remainder is below the divisor.
      if (!w_diff[WIDTH]) begin
        o_acc_next = w_diff[WIDTH-1:0];
        o_q_next   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc_next = w_shl[WIDTH-1:0];
        o_q_next   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for EX with pipeline stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier (IDLE->FIX), divide unchanged.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  op_t              w_op;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0] w_step_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
`endif

  always_comb begin
    w_signed   = ~funct[0];
    w_op       = funct[1] ? OP_DIV : OP_MUL;
    w_a_neg    = w_signed & rs_data[WIDTH-1];
    w_b_neg    = w_signed & rt_data[WIDTH-1];
    w_abs_a    = w_a_neg ? -rs_data : rs_data;
    w_abs_b    = w_b_neg ? -rt_data : rt_data;
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quot     = r_neg_q ? -r_q : r_q;
    w_rem      = r_neg_r ? -r_acc : r_acc;
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast_prod = w_abs_a * w_abs_b;
`endif

  muldiv_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op       (r_op),
    .i_acc      (r_acc),
    .i_q        (r_q),
    .i_b        (r_b),
    .o_acc_next (w_step_acc),
    .o_q_next   (w_step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_MUL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_b        <= '0;
      r_dividend <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            if (funct == FUNCT_MTHI) begin
              r_hi <= rs_data;
            end else if (funct == FUNCT_MTLO) begin
              r_lo <= rs_data;
            end else if (is_arith(funct)) begin
              // Operands run as magnitudes; sign flags restore the result in FIX.
              r_op       <= w_op;
              r_cnt      <= '0;
              r_acc      <= '0;
              r_q        <= w_abs_a;
              r_b        <= w_abs_b;
              r_dividend <= rs_data;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_div_zero <= (rt_data == '0);
              r_busy     <= 1'b1;
              r_state    <= ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
              if (w_op == OP_MUL) begin
                r_acc   <= w_fast_prod[2*WIDTH-1:WIDTH];
                r_q     <= w_fast_prod[WIDTH-1:0];
                r_state <= ST_FIX;
              end
`endif
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_op == OP_MUL) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (r_div_zero) begin
            r_hi <= r_dividend;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (funct == FUNCT_MFHI) begin
      rd_data = r_hi;
    end else if (funct == FUNCT_MFLO) begin
      rd_data = r_lo;
    end
  end

  assign stall = req && is_muldiv(funct) && r_busy;
  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32), one task per scenario.
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int bcnt;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .funct   (funct),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; funct = f; rs_data = a; rt_data = b;
    tick();
    req = 1'b0; funct = 6'd0; rs_data = '0; rt_data = '0;
  endtask

  // Counts edges from accept until done is seen, and cycles with busy high.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = busy ? 1 : 0;
    while (!done && l < 200) begin
      tick();
      l++;
      if (busy) bc++;
    end
  endtask

  task automatic check_arith(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int exp_lat);
    issue(f, a, b);
    wait_done(lat, bcnt);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_err++; $display("FAIL %s_hilo: got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
    end
    $display("%s rs=%h rt=%h -> hi=%h lo=%h lat=%0d", name, a, b, hi, lo, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; funct = F_MFHI; rs_data = '0; rt_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy, done, stall);
    end
    n_vec++;
    if (hi !== 32'h0 || lo !== 32'h0 || rd_data !== 32'h0) begin
      n_err++; $display("FAIL reset_regs: got hi=%h lo=%h rd=%h expected 0", hi, lo, rd_data);
    end
    funct = 6'd0;
    $display("reset -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult();
    check_arith("mult_neg", F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT);
    n_vec++;
    if (bcnt !== MUL_BUSY) begin
      n_err++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bcnt, MUL_BUSY);
    end
    check_arith("multu", F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MUL_LAT);
  endtask

  task automatic test_div();
    check_arith("div_neg", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: got %b expected 0", done);
    end
    check_arith("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
  endtask

  task automatic test_div_zero();
    check_arith("divu_zero", F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, DIV_LAT);
    n_vec++;
    if (bcnt !== DIV_BUSY) begin
      n_err++; $display("FAIL divzero_busy_cycles: got %0d expected %0d", bcnt, DIV_BUSY);
    end
  endtask

  task automatic test_stall();
    int g;
    issue(F_MTHI, 32'hAAAA0000, 32'h0);
    issue(F_MTLO, 32'h00005555, 32'h0);
    issue(F_MULT, 32'h40000000, 32'h00000010);
    g = 0;
    while (!done && g < 200) begin
      req = 1'b1; funct = g[0] ? F_MTLO : F_MFHI; rs_data = 32'hDEADBEEF;
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++; $display("FAIL stall_busy: cycle %0d got %b expected 1", g, stall);
      end
      tick();
      g++;
      if (!done) begin
        n_vec++;
        if (hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin
          n_err++; $display("FAIL stall_hold: got %h_%h expected aaaa0000_00005555", hi, lo);
        end
      end
    end
    n_vec++;
    if (hi !== 32'h00000004 || lo !== 32'h00000000) begin
      n_err++; $display("FAIL stall_result: got %h_%h expected 00000004_00000000", hi, lo);
    end
    req = 1'b1; funct = F_MFHI; rs_data = '0;
    #1;
    n_vec++;
    if (stall !== 1'b0 || rd_data !== 32'h00000004) begin
      n_err++; $display("FAIL mfhi_after_done: got stall=%b rd=%h expected 0 00000004", stall, rd_data);
    end
    $display("stall test -> %0d stalled cycles, hi=%h lo=%h", g, hi, lo);
    tick();
    req = 1'b0; funct = 6'd0;
  endtask

  task automatic test_mt_mf();
    issue(F_MTHI, 32'h12345678, 32'h0);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL mthi_busy: got %b expected 0", busy);
    end
    req = 1'b1; funct = F_MFHI;
    #1;
    n_vec++;
    if (rd_data !== 32'h12345678) begin
      n_err++; $display("FAIL mfhi: got %h expected 12345678", rd_data);
    end
    req = 1'b0;
    issue(F_MTLO, 32'h9ABCDEF0, 32'h0);
    req = 1'b1; funct = F_MFLO;
    #1;
    n_vec++;
    if (rd_data !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      n_err++; $display("FAIL mflo: got rd=%h hi=%h expected 9abcdef0 12345678", rd_data, hi);
    end
    req = 1'b0;
    req = 1'b1; funct = F_ADD; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL unrelated_stall: got %b expected 0", stall);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      n_err++; $display("FAIL unrelated_state: got busy=%b hi=%h lo=%h", busy, hi, lo);
    end
    req = 1'b0; funct = 6'd0; rs_data = '0; rt_data = '0;
    $display("mt/mf -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_abort();
    issue(F_DIV, 32'h00000064, 32'h00000003);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_err++; $display("FAIL abort_state: got busy=%b done=%b hi=%h lo=%h expected 0", busy, done, hi, lo);
    end
    check_arith("mult_6x7", F_MULT, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, MUL_LAT);
  endtask

  task automatic test_back_to_back();
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    n_vec++;
    if (lat !== DIV_LAT || hi !== 32'd2 || lo !== 32'd14) begin
      n_err++; $display("FAIL b2b_divu: got lat=%0d hi=%h lo=%h expected 33 2 e", lat, hi, lo);
    end
    check_arith("b2b_multu", F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; funct = 6'd0; rs_data = '0; rt_data = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_mt_mf();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
